branch_resolve: RTL and testbench

- Consumer end of the condition-code interface. Captures the six condition codes (EQ, LT, GT, LE, GE, NE) produced each cycle a flag-setting ALU op completes.
- Holds the codes in a flag register. Resolves conditional branches against them.
- Stalls issue while the flags a branch needs are still in flight. Issues a registered PC redirect plus a timed pipeline flush when a branch is taken.
- Sits between decode/issue and fetch.

---
 rtl/branch_resolve.sv | 142 ++++++++++++++
 tb/tb_branch_resolve.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - condition-code capture, branch resolution, redirect and timed flush
module branch_resolve #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cc_valid,
  input  logic [5:0]      cc_in,
  input  logic            flags_pending,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic            br_ready,
  output logic            stall,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic [5:0]      cc_q,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_CC, S_FLUSH} state_t;

  localparam logic [3:0] LP_FLUSH = 4'(FLUSH_CYCLES);

  state_t          r_state;
  logic [5:0]      r_cc;
  logic            r_stall;
  logic            r_redirect;
  logic [PC_W-1:0] r_redirect_pc;
  logic            r_flush;
  logic [3:0]      r_fcnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [2:0]      r_br_cond;
  logic [PC_W-1:0] r_br_target;

  logic [5:0]      w_eff;
  logic            w_hazard;
  logic            w_taken_now;
  logic            w_taken_wait;
  logic            w_go;
  logic [PC_W-1:0] w_go_pc;
  logic [CNT_W-1:0] w_cnt_next;

  // cc bit order is {NE,GE,LE,GT,LT,EQ}; all-zero flags naturally fail every conditional test
  function automatic logic f_sel(input logic [2:0] c, input logic [5:0] f);
    logic v;
    v = 1'b0;
    case (c)
      3'b000:  v = 1'b1;
      3'b001:  v = f[0];
      3'b010:  v = f[5];
      3'b011:  v = f[1];
      3'b100:  v = f[2];
      3'b101:  v = f[3];
      3'b110:  v = f[4];
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  always_comb begin
    w_eff        = cc_valid ? cc_in : r_cc;
    w_hazard     = br_valid & flags_pending & ~cc_valid &
                   (br_cond != 3'b000) & (br_cond != 3'b111);
    w_taken_now  = f_sel(br_cond, w_eff);
    w_taken_wait = f_sel(r_br_cond, cc_in);
    w_go         = 1'b0;
    w_go_pc      = br_target;
    if (r_state == S_IDLE) begin
      w_go = br_valid & ~w_hazard & w_taken_now;
    end else if (r_state == S_WAIT_CC) begin
      w_go    = cc_valid & w_taken_wait;
      w_go_pc = r_br_target;
    end
    w_cnt_next = (&r_taken_cnt) ? r_taken_cnt : r_taken_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cc          <= '0;
      r_stall       <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_flush       <= 1'b0;
      r_fcnt        <= '0;
      r_taken_cnt   <= '0;
      r_br_cond     <= '0;
      r_br_target   <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cc_valid) r_cc <= cc_in;
          if (w_hazard) begin
            r_br_cond   <= br_cond;
            r_br_target <= br_target;
            r_stall     <= 1'b1;
            r_state     <= S_WAIT_CC;
          end
        end
        S_WAIT_CC: begin
          if (cc_valid) begin
            r_cc    <= cc_in;
            r_stall <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_FLUSH: begin
          // flags arriving here belong to squashed ops and are dropped
          if (r_fcnt == 4'd1) begin
            r_flush <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_fcnt <= r_fcnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_go) begin
        r_redirect    <= 1'b1;
        r_redirect_pc <= w_go_pc;
        r_flush       <= 1'b1;
        r_fcnt        <= LP_FLUSH;
        r_taken_cnt   <= w_cnt_next;
        r_state       <= S_FLUSH;
      end
    end
  end

  assign br_ready    = (r_state == S_IDLE) & br_valid;
  assign stall       = r_stall;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign flush       = r_flush;
  assign cc_q        = r_cc;
  assign taken_cnt   = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - self-checking bench for branch_resolve
module tb_branch_resolve;
  localparam int PC_W    = 32;
  localparam int FC      = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cc_valid;
  logic [5:0]       cc_in;
  logic             flags_pending;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic [PC_W-1:0]  br_target;
  logic             br_ready;
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic [5:0]       cc_q;
  logic [CNT_W-1:0] taken_cnt;

  always #5 clk = ~clk;

  branch_resolve #(.PC_W(PC_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cc_valid(cc_valid), .cc_in(cc_in),
    .flags_pending(flags_pending), .br_valid(br_valid), .br_cond(br_cond),
    .br_target(br_target), .br_ready(br_ready), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .cc_q(cc_q), .taken_cnt(taken_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [5:0]      m_cc;
  int              m_cnt;
  logic [PC_W-1:0] m_pc;
  // which flag bit each condition code tests; -1 marks always/never
  int bit_of[8] = '{-1, 0, 5, 1, 2, 3, 4, -1};

  function automatic bit m_taken(input logic [2:0] c, input logic [5:0] f);
    if (c == 3'd0) return 1'b1;
    if (c == 3'd7) return 1'b0;
    return f[bit_of[c]];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    br_valid = 1'b0; cc_valid = 1'b0; flags_pending = 1'b0;
    cc_in = '0; br_cond = '0; br_target = '0;
  endtask

  task automatic model_reset();
    m_cc = '0; m_cnt = 0; m_pc = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_stall"},    64'(stall), 64'(0));
    chk({tag, "_redirect"}, 64'(redirect), 64'(0));
    chk({tag, "_flush"},    64'(flush), 64'(0));
    chk({tag, "_cc_q"},     64'(cc_q), 64'(m_cc));
    chk({tag, "_cnt"},      64'(taken_cnt), 64'(m_cnt));
    chk({tag, "_pc"},       64'(redirect_pc), 64'(m_pc));
  endtask

  // Starts and ends at a falling edge with the DUT idle.
  task automatic branch_tx(input logic [2:0] cond, input logic [PC_W-1:0] tgt,
                           input bit with_cc, input logic [5:0] cc,
                           input bit pending, input int delay);
    bit hz;
    bit tk;
    hz = pending && !with_cc && cond != 3'd0 && cond != 3'd7;
    br_valid = 1'b1; br_cond = cond; br_target = tgt;
    flags_pending = pending; cc_valid = with_cc; cc_in = cc;
    #1 chk("br_ready_idle", 64'(br_ready), 64'(1));
    if (with_cc) m_cc = cc;
    if (hz) begin
      for (int k = 1; k <= delay; k++) begin
        @(negedge clk);
        clear_in();
        chk("stall_wait", 64'(stall), 64'(1));
        chk("redirect_wait", 64'(redirect), 64'(0));
        br_valid = 1'b1; br_cond = 3'($urandom); br_target = $urandom; flags_pending = 1'b1;
        #1 chk("br_ready_wait", 64'(br_ready), 64'(0));
        if (k == delay) begin
          cc_valid = 1'b1; cc_in = cc; m_cc = cc;
        end
      end
    end
    tk = m_taken(cond, m_cc);
    @(negedge clk);
    clear_in();
    if (tk) begin
      m_pc  = tgt;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    chk("redirect", 64'(redirect), 64'(tk));
    chk("flush_first", 64'(flush), 64'(tk));
    chk("redirect_pc", 64'(redirect_pc), 64'(m_pc));
    chk("stall_resolved", 64'(stall), 64'(0));
    chk("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
    chk("cc_q", 64'(cc_q), 64'(m_cc));
    if (tk) begin
      for (int i = 1; i <= FC; i++) begin
        if (i > 1) begin
          @(negedge clk);
          chk("redirect_pulse", 64'(redirect), 64'(0));
          chk("flush_hold", 64'(flush), 64'(1));
        end
        br_valid = 1'b1; br_cond = 3'd0; br_target = $urandom;
        cc_valid = 1'b1; cc_in = 6'b101001;
        #1 chk("br_ready_flush", 64'(br_ready), 64'(0));
      end
      @(negedge clk);
      clear_in();
      check_idle("post_flush");
    end
  endtask

  initial begin
    bit          wc;
    bit          pd;
    logic [5:0]  rc;
    clear_in();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    branch_tx(3'b001, 32'h100, 1'b0, 6'd0, 1'b0, 0);
    branch_tx(3'b000, 32'h100, 1'b0, 6'd0, 1'b0, 0);
    branch_tx(3'b001, 32'h2000, 1'b1, 6'b101001, 1'b0, 0);
    branch_tx(3'b011, 32'h40, 1'b0, 6'b110010, 1'b1, 3);
    branch_tx(3'b001, 32'h300, 1'b1, 6'b000000, 1'b0, 0);
    for (int c = 2; c <= 6; c++) branch_tx(3'(c), 32'h400 + 32'(c), 1'b0, 6'd0, 1'b0, 0);
    branch_tx(3'b000, 32'h500, 1'b0, 6'd0, 1'b0, 0);
    branch_tx(3'b111, 32'h600, 1'b1, 6'b111111, 1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      wc = 1'($urandom);
      pd = 1'($urandom);
      rc = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
      branch_tx(3'($urandom_range(0, 7)), $urandom, wc, rc, pd, $urandom_range(1, 4));
    end

    // reset in the middle of a flush
    br_valid = 1'b1; br_cond = 3'd0; br_target = 32'hABCD;
    @(negedge clk);
    clear_in();
    chk("pre_rst_flush", 64'(flush), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_idle("rst_flush");
    br_valid = 1'b1; br_cond = 3'b001;
    #1 chk("rst_flush_ready", 64'(br_ready), 64'(1));
    @(negedge clk);
    clear_in();
    chk("rst_flush_eq_not_taken", 64'(redirect), 64'(0));

    // reset while waiting on flags
    br_valid = 1'b1; br_cond = 3'b010; br_target = 32'h77; flags_pending = 1'b1;
    @(negedge clk);
    clear_in();
    chk("pre_rst_wait", 64'(stall), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("rst_wait");

    for (int n = 0; n < CNT_MAX + 3; n++) branch_tx(3'b000, $urandom, 1'b0, 6'd0, 1'b0, 0);
    chk("saturated", 64'(taken_cnt), 64'(CNT_MAX));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
